// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small transmit FIFO in front of the framing FSM.
// Frames are start, data LSB first, optional parity, then 1 or 2 stop bits.
//
// Ports:
//   CLK, RST        clock; asynchronous active-high reset
//   P_DATA          parallel word, written when Data_Valid and ready
//   parity_enable   1 = insert parity bit
//   parity_type     0 = even, 1 = odd
//   stop_bits_2     0 = one stop bit, 1 = two stop bits
//   prescale        each bit lasts prescale+1 CLK cycles
//   S_DATA          registered serial line, idles high
//   busy            frame in progress or FIFO not empty
//   ready           FIFO has a free entry
//   fifo_count      occupied FIFO entries
module uart_tx_fifo #(
    parameter int DATA_WIDTH     = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [DATA_WIDTH-1:0]         P_DATA,
    input  logic                          Data_Valid,
    input  logic                          parity_enable,
    input  logic                          parity_type,
    input  logic                          stop_bits_2,
    input  logic [PRESCALE_WIDTH-1:0]     prescale,
    output logic                          S_DATA,
    output logic                          busy,
    output logic                          ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(DATA_WIDTH);

    localparam logic [AW:0]               FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [BW-1:0]             LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0]             ONE_B    = BW'(1);
    localparam logic [PRESCALE_WIDTH-1:0] ONE_T    = PRESCALE_WIDTH'(1);
    localparam logic [AW-1:0]             ONE_P    = AW'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // FIFO storage and pointers
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head;

    // Frame registers, captured when the head word is popped
    logic [DATA_WIDTH-1:0]     f_shift;
    logic                      f_pe;
    logic                      f_par;
    logic                      f_s2;
    logic [PRESCALE_WIDTH-1:0] f_ps;

    // FSM state and counters
    state_t                    state;
    state_t                    state_n;
    logic [PRESCALE_WIDTH-1:0] tick;
    logic [PRESCALE_WIDTH-1:0] tick_n;
    logic [BW-1:0]             bit_idx;
    logic [BW-1:0]             bit_n;
    logic                      stop_idx;
    logic                      stop_n;
    logic                      sdata_n;
    logic                      shift_en;
    logic                      bit_done;

    assign ready = (fifo_count < FULL_CNT);
    assign push  = Data_Valid & ready;
    assign head  = mem[rd_ptr];
    assign busy  = (state != IDLE) || (fifo_count != '0);

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= P_DATA;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ONE_P;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ONE_P;
            end
            fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_comb begin
        state_n  = state;
        tick_n   = tick;
        bit_n    = bit_idx;
        stop_n   = stop_idx;
        sdata_n  = S_DATA;
        pop      = 1'b0;
        shift_en = 1'b0;
        bit_done = (tick == '0);
        unique case (state)
            IDLE: begin
                if (fifo_count != '0) begin
                    pop     = 1'b1;
                    state_n = START;
                    tick_n  = prescale;
                    sdata_n = 1'b0;
                end
            end
            START: begin
                if (bit_done) begin
                    state_n = DATA;
                    tick_n  = f_ps;
                    bit_n   = '0;
                    sdata_n = f_shift[0];
                end else begin
                    tick_n = tick - ONE_T;
                end
            end
            DATA: begin
                if (bit_done) begin
                    tick_n = f_ps;
                    if (bit_idx == LAST_BIT) begin
                        bit_n = '0;
                        if (f_pe) begin
                            state_n = PARITY;
                            sdata_n = f_par;
                        end else begin
                            state_n = STOP;
                            stop_n  = 1'b0;
                            sdata_n = 1'b1;
                        end
                    end else begin
                        bit_n    = bit_idx + ONE_B;
                        shift_en = 1'b1;
                        // next data bit is the one behind the current LSB
                        sdata_n  = f_shift[1];
                    end
                end else begin
                    tick_n = tick - ONE_T;
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_n = STOP;
                    tick_n  = f_ps;
                    stop_n  = 1'b0;
                    sdata_n = 1'b1;
                end else begin
                    tick_n = tick - ONE_T;
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (f_s2 && !stop_idx) begin
                        stop_n = 1'b1;
                        tick_n = f_ps;
                    end else if (fifo_count != '0) begin
                        // back-to-back: next start bit with no idle gap
                        pop     = 1'b1;
                        state_n = START;
                        tick_n  = prescale;
                        sdata_n = 1'b0;
                    end else begin
                        state_n = IDLE;
                        sdata_n = 1'b1;
                    end
                end else begin
                    tick_n = tick - ONE_T;
                end
            end
            default: begin
                state_n = IDLE;
                sdata_n = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            tick     <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            S_DATA   <= 1'b1;
        end else begin
            state    <= state_n;
            tick     <= tick_n;
            bit_idx  <= bit_n;
            stop_idx <= stop_n;
            S_DATA   <= sdata_n;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            f_shift <= '0;
            f_pe    <= 1'b0;
            f_par   <= 1'b0;
            f_s2    <= 1'b0;
            f_ps    <= '0;
        end else if (pop) begin
            f_shift <= head;
            f_pe    <= parity_enable;
            f_par   <= (^head) ^ parity_type;
            f_s2    <= stop_bits_2;
            f_ps    <= prescale;
        end else if (shift_en) begin
            f_shift <= f_shift >> 1;
        end
    end

endmodule
